// File: rtl/memory_pkg.sv
// memory_pkg
// Shared types and helpers for the dual-port BRAM family.
//   mem_state_e  : zero-fill sequencer states (MEM_CLEAR, MEM_READY)
//   lanes()      : number of byte lanes in a word
//   merge_lanes(): per-lane merge of an old and a new word under a lane mask,
//                  used by both the array write path and the collision bypass
// Words are handled at MaxDataWidth inside the helpers so one function serves
// every parametrisation; callers widen their operands and truncate the result.
package memory_pkg;

    localparam int MaxDataWidth = 256;

    typedef logic [MaxDataWidth-1:0] max_word_t;

    typedef enum logic {
        MEM_CLEAR = 1'b0,
        MEM_READY = 1'b1
    } mem_state_e;

    function automatic int lanes(input int data_width, input int byte_width);
        return data_width / byte_width;
    endfunction

    // Bit i belongs to lane i/byte_width; an enabled lane takes the new word.
    function automatic max_word_t merge_lanes(input max_word_t old_word,
                                              input max_word_t new_word,
                                              input max_word_t byteen,
                                              input int        byte_width);
        max_word_t result;
        result = old_word;
        for (int i = 0; i < MaxDataWidth; i++) begin
            if (byteen[i / byte_width]) begin
                result[i] = new_word[i];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_clear_seq.sv
// mem_clear_seq
// Post-reset zero-fill sequencer for the dual-port BRAM.
// Walks the address space once after reset, steering a zero write into the
// array at each negedge, then parks in MEM_READY with ready held high.
// Ports:
//   clk        in   clock, state updates on negedge
//   reset      in   synchronous active-high reset
//   clear_sel  out  high while the array write port belongs to the sequencer
//   clear_addr out  address being zeroed this edge
//   ready      out  registered flag, high once user accesses are accepted
module mem_clear_seq
    import memory_pkg::*;
#(
    parameter int AddrWidth    = 8,
    parameter int ClearOnReset = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 clear_sel,
    output logic [AddrWidth-1:0] clear_addr,
    output logic                 ready
);

    localparam mem_state_e ResetState =
        mem_state_e'((ClearOnReset != 0) ? MEM_CLEAR : MEM_READY);

    mem_state_e           state_q, state_d;
    logic [AddrWidth-1:0] cnt_q, cnt_d;
    logic                 ready_q, ready_d;

    // State register; a reset during the fill restarts it from address 0.
    always_ff @(negedge clk) begin
        if (reset) begin
            state_q <= ResetState;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // The last address is written on the same edge that raises ready, so the
    // whole fill takes exactly depth edges.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
        case (state_q)
            MEM_CLEAR: begin
                cnt_d = cnt_q + AddrWidth'(1);
                if (cnt_q == '1) begin
                    state_d = MEM_READY;
                    ready_d = 1'b1;
                end
            end
            MEM_READY: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d = ResetState;
            end
        endcase
    end

    assign clear_sel  = (state_q == MEM_CLEAR);
    assign clear_addr = cnt_q;
    assign ready      = ready_q;

endmodule

// File: rtl/dual_port_bram.sv
// dual_port_bram
// Simple dual-port block RAM: one write port, one read port, one clock,
// every register updating on the falling edge.
// Ports:
//   Clk       in   clock (negedge active)
//   Reset     in   synchronous active-high reset
//   Wr_EN     in   write strobe, active low
//   WrAddr    in   write address
//   WrData    in   write data
//   WrByteEn  in   per-lane write enables, active high
//   Rd_EN     in   read strobe, active low
//   RdAddr    in   read address
//   RdData    out  registered read data
//   RdValid   out  one-edge pulse marking RdData as new
//   Ready     out  high when user accesses are accepted
// Array contents survive reset; the zero-fill sequencer clears them afterwards
// when ClearOnReset is set.
module dual_port_bram
    import memory_pkg::*;
#(
    parameter int AddrWidth    = 8,
    parameter int DataWidth    = 16,
    parameter int ByteWidth    = 8,
    parameter int ReadLatency  = 1,
    parameter int WriteFirst   = 1,
    parameter int ClearOnReset = 1
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           Wr_EN,
    input  logic [AddrWidth-1:0]           WrAddr,
    input  logic [DataWidth-1:0]           WrData,
    input  logic [DataWidth/ByteWidth-1:0] WrByteEn,
    input  logic                           Rd_EN,
    input  logic [AddrWidth-1:0]           RdAddr,
    output logic [DataWidth-1:0]           RdData,
    output logic                           RdValid,
    output logic                           Ready
);

    localparam int Depth = 1 << AddrWidth;
    localparam int Lanes = lanes(DataWidth, ByteWidth);

    generate
        if (ByteWidth < 1 || Lanes * ByteWidth != DataWidth) begin : g_bad_lanes
            $error("dual_port_bram: DataWidth must be a multiple of ByteWidth");
        end
        if (DataWidth > MaxDataWidth) begin : g_bad_width
            $error("dual_port_bram: DataWidth exceeds memory_pkg::MaxDataWidth");
        end
        if (ReadLatency != 1 && ReadLatency != 2) begin : g_bad_latency
            $error("dual_port_bram: ReadLatency must be 1 or 2");
        end
    endgenerate

    logic [DataWidth-1:0] mem [Depth];

    logic                 clear_sel;
    logic [AddrWidth-1:0] clear_addr;
    logic                 wr_fire;
    logic                 rd_fire;
    logic                 collision;
    logic [DataWidth-1:0] merged_word;
    logic [DataWidth-1:0] rd_word;

    mem_clear_seq #(
        .AddrWidth   (AddrWidth),
        .ClearOnReset(ClearOnReset)
    ) u_clear_seq (
        .clk       (Clk),
        .reset     (Reset),
        .clear_sel (clear_sel),
        .clear_addr(clear_addr),
        .ready     (Ready)
    );

    // User strobes only count once the array is ready, which also makes them
    // inert during the zero-fill.
    assign wr_fire = Ready && !Wr_EN && !Reset;
    assign rd_fire = Ready && !Rd_EN && !Reset;

    // One merged word feeds both the array write and the write-first bypass,
    // so the array and the returned word can never disagree.
    assign merged_word = DataWidth'(merge_lanes(max_word_t'(mem[WrAddr]),
                                                max_word_t'(WrData),
                                                max_word_t'(WrByteEn),
                                                ByteWidth));
    assign collision   = wr_fire && (WrAddr == RdAddr);
    assign rd_word     = (WriteFirst == 1 && collision) ? merged_word : mem[RdAddr];

    // Array write port, muxed between the zero-fill sequencer and the user.
    always_ff @(negedge Clk) begin
        if (!Reset) begin
            if (clear_sel) begin
                mem[clear_addr] <= '0;
            end else if (wr_fire) begin
                mem[WrAddr] <= merged_word;
            end
        end
    end

    generate
        if (ReadLatency == 1) begin : g_lat1
            // Single stage: captured word goes straight to the output register.
            always_ff @(negedge Clk) begin
                if (Reset) begin
                    RdData  <= '0;
                    RdValid <= 1'b0;
                end else begin
                    RdValid <= rd_fire;
                    if (rd_fire) begin
                        RdData <= rd_word;
                    end
                end
            end
        end else begin : g_lat2
            logic [DataWidth-1:0] stage_data;
            logic                 stage_valid;

            // Two stages; reset clears the stage valid so an in-flight read
            // never surfaces.
            always_ff @(negedge Clk) begin
                if (Reset) begin
                    stage_data  <= '0;
                    stage_valid <= 1'b0;
                    RdData      <= '0;
                    RdValid     <= 1'b0;
                end else begin
                    stage_valid <= rd_fire;
                    if (rd_fire) begin
                        stage_data <= rd_word;
                    end
                    RdValid <= stage_valid;
                    if (stage_valid) begin
                        RdData <= stage_data;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_dual_port_bram.sv
// tb_dual_port_bram
// Drives two BRAM instances from the same stimulus: instance A uses one-edge
// read latency with write-first collisions, instance B two-edge latency with
// read-first collisions. Expected read words are queued per instance when a
// read is issued and popped when that instance raises RdValid.
module tb_dual_port_bram;

    logic        Clk      = 1'b1;
    logic        Reset    = 1'b1;
    logic        Wr_EN    = 1'b1;
    logic        Rd_EN    = 1'b1;
    logic [7:0]  WrAddr   = '0;
    logic [7:0]  RdAddr   = '0;
    logic [15:0] WrData   = '0;
    logic [1:0]  WrByteEn = '0;

    logic [15:0] rdDataA, rdDataB;
    logic        rdValidA, rdValidB;
    logic        readyA, readyB;

    int checkCount = 0;
    int passCount  = 0;

    logic [15:0] expQueueA[$];
    logic [15:0] expQueueB[$];

    logic readyModel      = 1'b0;
    int   clearCountModel = 0;
    bit   clearingModel   = 1'b1;
    bit   pendingB        = 1'b0;

    always #5 Clk = ~Clk;

    dual_port_bram #(
        .AddrWidth(8), .DataWidth(16), .ByteWidth(8),
        .ReadLatency(1), .WriteFirst(1), .ClearOnReset(1)
    ) dutA (
        .Clk(Clk), .Reset(Reset), .Wr_EN(Wr_EN), .WrAddr(WrAddr),
        .WrData(WrData), .WrByteEn(WrByteEn), .Rd_EN(Rd_EN), .RdAddr(RdAddr),
        .RdData(rdDataA), .RdValid(rdValidA), .Ready(readyA)
    );

    dual_port_bram #(
        .AddrWidth(8), .DataWidth(16), .ByteWidth(8),
        .ReadLatency(2), .WriteFirst(0), .ClearOnReset(1)
    ) dutB (
        .Clk(Clk), .Reset(Reset), .Wr_EN(Wr_EN), .WrAddr(WrAddr),
        .WrData(WrData), .WrByteEn(WrByteEn), .Rd_EN(Rd_EN), .RdAddr(RdAddr),
        .RdData(rdDataB), .RdValid(rdValidB), .Ready(readyB)
    );

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    function automatic logic [15:0] pattern(input int i);
        return 16'((i * 257) ^ 16'h5A5A);
    endfunction

    // One negedge of stimulus: drive, update the reference timing model,
    // wait for the edge, then compare Ready, RdValid and any completed read.
    task automatic applyStimulus(input bit rst, input bit doWr,
                                 input logic [7:0] wa, input logic [15:0] wd,
                                 input logic [1:0] be, input bit doRd,
                                 input logic [7:0] ra, input logic [15:0] expA,
                                 input logic [15:0] expB);
        bit rdAccepted;
        bit expValidA;
        bit expValidB;
        Reset    = rst;
        Wr_EN    = ~doWr;
        WrAddr   = wa;
        WrData   = wd;
        WrByteEn = be;
        Rd_EN    = ~doRd;
        RdAddr   = ra;

        rdAccepted = !rst && readyModel && doRd;
        expValidA  = rdAccepted;
        expValidB  = !rst && pendingB;
        if (rst && pendingB && expQueueB.size() > 0) begin
            void'(expQueueB.pop_back());
        end
        if (rdAccepted) begin
            expQueueA.push_back(expA);
            expQueueB.push_back(expB);
        end
        if (rst) begin
            readyModel      = 1'b0;
            clearCountModel = 0;
            clearingModel   = 1'b1;
        end else if (clearingModel) begin
            if (clearCountModel == 255) begin
                clearingModel = 1'b0;
                readyModel    = 1'b1;
            end
            clearCountModel++;
        end
        pendingB = rdAccepted;

        @(negedge Clk);
        #1;
        checkOutput("ready_a", 32'(readyA), 32'(readyModel));
        checkOutput("ready_b", 32'(readyB), 32'(readyModel));
        checkOutput("rdvalid_a", 32'(rdValidA), 32'(expValidA));
        checkOutput("rdvalid_b", 32'(rdValidB), 32'(expValidB));
        if (rdValidA && expQueueA.size() > 0) begin
            checkOutput("rddata_a", 32'(rdDataA), 32'(expQueueA.pop_front()));
        end
        if (rdValidB && expQueueB.size() > 0) begin
            checkOutput("rddata_b", 32'(rdDataB), 32'(expQueueB.pop_front()));
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 8'h00, 16'h0000, 2'b00, 1'b0, 8'h00, 16'h0, 16'h0);
    endtask

    task automatic doIdle();
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, 2'b00, 1'b0, 8'h00, 16'h0, 16'h0);
    endtask

    task automatic doWrite(input logic [7:0] a, input logic [15:0] d,
                           input logic [1:0] be);
        applyStimulus(1'b0, 1'b1, a, d, be, 1'b0, 8'h00, 16'h0, 16'h0);
    endtask

    task automatic doRead(input logic [7:0] a, input logic [15:0] expA,
                          input logic [15:0] expB);
        applyStimulus(1'b0, 1'b0, 8'h00, 16'h0000, 2'b00, 1'b1, a, expA, expB);
    endtask

    initial begin
        $display("[TB] dual_port_bram bench starting");

        // Reset state of both instances.
        doReset();
        checkOutput("rst_rddata_a", 32'(rdDataA), 32'h0);
        checkOutput("rst_rddata_b", 32'(rdDataB), 32'h0);
        doReset();

        // Zero-fill: Ready low for 255 edges, high on the 256th; a write and a
        // read attempted mid-fill must both be ignored.
        for (int i = 0; i < 256; i++) begin
            if (i == 10) begin
                applyStimulus(1'b0, 1'b1, 8'h05, 16'hFFFF, 2'b11, 1'b1, 8'h05,
                              16'h0, 16'h0);
            end else begin
                doIdle();
            end
        end

        // Cleared contents, including the address written during the fill.
        doRead(8'h00, 16'h0000, 16'h0000);
        doRead(8'h7F, 16'h0000, 16'h0000);
        doRead(8'hFF, 16'h0000, 16'h0000);
        doRead(8'h05, 16'h0000, 16'h0000);
        doIdle();

        // Byte-lane write merge.
        doWrite(8'h10, 16'hBEEF, 2'b11);
        doWrite(8'h10, 16'h1234, 2'b01);
        doRead(8'h10, 16'hBE34, 16'hBE34);
        doIdle();

        // Back-to-back reads, one result per edge in issue order.
        doWrite(8'h01, 16'h00A1, 2'b11);
        doWrite(8'h02, 16'h00A2, 2'b11);
        doWrite(8'h03, 16'h00A3, 2'b11);
        doRead(8'h01, 16'h00A1, 16'h00A1);
        doRead(8'h02, 16'h00A2, 16'h00A2);
        doRead(8'h03, 16'h00A3, 16'h00A3);
        doIdle();
        doIdle();

        // Same-address collision: A returns the merged word, B the old word.
        doWrite(8'h20, 16'h5555, 2'b11);
        applyStimulus(1'b0, 1'b1, 8'h20, 16'hAAAA, 2'b10, 1'b1, 8'h20,
                      16'hAA55, 16'h5555);
        doRead(8'h20, 16'hAA55, 16'hAA55);
        doIdle();

        // A write with no lanes enabled leaves the word unchanged.
        doWrite(8'h20, 16'hFFFF, 2'b00);
        doRead(8'h20, 16'hAA55, 16'hAA55);
        doIdle();

        // Independent concurrent write and read at different addresses.
        for (int i = 0; i < 16; i++) begin
            doWrite(8'(8'h40 + i), pattern(i), 2'b11);
        end
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 1'b1, 8'(8'h80 + i), ~pattern(i), 2'b11,
                          1'b1, 8'(8'h40 + i), pattern(i), pattern(i));
        end
        for (int i = 0; i < 16; i++) begin
            doRead(8'(8'h80 + i), ~pattern(i), ~pattern(i));
        end
        doIdle();
        doIdle();

        // Reset right behind a read drops B's in-flight result.
        doRead(8'h10, 16'hBE34, 16'hBE34);
        doReset();
        checkOutput("midrd_rddata_a", 32'(rdDataA), 32'h0);
        checkOutput("midrd_rddata_b", 32'(rdDataB), 32'h0);
        doReset();

        // Reset at clear count 100 restarts the fill from zero.
        for (int i = 0; i < 100; i++) begin
            doIdle();
        end
        doReset();
        for (int i = 0; i < 256; i++) begin
            doIdle();
        end

        // The fill zeroed previously written words.
        doRead(8'h10, 16'h0000, 16'h0000);
        doRead(8'h20, 16'h0000, 16'h0000);
        doRead(8'h45, 16'h0000, 16'h0000);
        doIdle();
        doIdle();

        checkOutput("drain_a", 32'(expQueueA.size()), 32'h0);
        checkOutput("drain_b", 32'(expQueueB.size()), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
